// File: rtl/pairing_result_reader.sv
// Streams a block of pairing-core result words out over a valid/ready channel.
// Optional busy-wait timeout is enabled by defining PAIRING_RDR_TIMEOUT_EN.
module pairing_result_reader #(
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [8:0]   base_addr,
    input  logic [4:0]   n_words,
    input  logic         busy_in,
    output logic [8:0]   extout_addr,
    input  logic [288:0] extout_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [288:0] m_data,
    output logic [3:0]   m_index,
    output logic         m_last,
    output logic         active,
    output logic         done,
    output logic         err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_BUSY = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_LAT  = 3'd3;
    localparam logic [2:0] S_PRESENT   = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    // Data becomes valid RD_LAT cycles after the address register is seen by the core,
    // so capture happens on the (RD_LAT+1)th WAIT_LAT cycle.
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT);

    logic [2:0]   state_q, state_d;
    logic [8:0]   base_q, base_d;
    logic [4:0]   n_q, n_d;
    logic [4:0]   idx_q, idx_d;
    logic [3:0]   lat_q, lat_d;
    logic [8:0]   addr_q, addr_d;
    logic [288:0] m_data_q, m_data_d;
    logic         m_valid_q, m_valid_d;
    logic [3:0]   m_index_q, m_index_d;
    logic         m_last_q, m_last_d;
    logic         active_q, active_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         beat_is_last_s;

`ifdef PAIRING_RDR_TIMEOUT_EN
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign beat_is_last_s = ((idx_q + 5'd1) == n_q);

    // Next-state and datapath computation for the read sequencer.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_d       = n_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        active_d  = active_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PAIRING_RDR_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    n_d      = (n_words > 5'd16) ? 5'd16 : n_words;
                    idx_d    = 5'd0;
                    active_d = 1'b1;
                    state_d  = S_WAIT_BUSY;
`ifdef PAIRING_RDR_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (!busy_in) begin
                    if (n_q != 5'd0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d  = S_FINISH;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end
                end else begin
`ifdef PAIRING_RDR_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`else
                    state_d = S_WAIT_BUSY;
`endif
                end
            end
            S_ISSUE: begin
                addr_d  = base_q + {4'd0, idx_q};
                lat_d   = 4'd0;
                state_d = S_WAIT_LAT;
            end
            S_WAIT_LAT: begin
                if (lat_q == LAT_LAST) begin
                    m_data_d  = extout_data;
                    m_valid_d = 1'b1;
                    m_index_d = idx_q[3:0];
                    m_last_d  = beat_is_last_s;
                    state_d   = S_PRESENT;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_PRESENT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (beat_is_last_s) begin
                        state_d  = S_FINISH;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                m_valid_d = 1'b0;
                active_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            base_q    <= 9'd0;
            n_q       <= 5'd0;
            idx_q     <= 5'd0;
            lat_q     <= 4'd0;
            addr_q    <= 9'd0;
            m_data_q  <= 289'd0;
            m_valid_q <= 1'b0;
            m_index_q <= 4'd0;
            m_last_q  <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PAIRING_RDR_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
            active_q  <= active_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PAIRING_RDR_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign extout_addr = addr_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_index     = m_index_q;
    assign m_last      = m_last_q;
    assign active      = active_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pairing_result_reader.sv
// Directed bench for pairing_result_reader with a latency-RD_LAT memory stub (data = addr*3+1).
module tb_pairing_result_reader;

    localparam int RD_LAT = 2;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [8:0]   base_addr;
    logic [4:0]   n_words;
    logic         busy_in;
    logic [8:0]   extout_addr;
    logic [288:0] extout_data;
    logic         m_valid;
    logic         m_ready;
    logic [288:0] m_data;
    logic [3:0]   m_index;
    logic         m_last;
    logic         active;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int addr_chg = 0;
    int valid_cnt = 0;

    logic [288:0] q_data[$];
    logic [3:0]   q_idx[$];
    logic         q_last[$];
    logic [8:0]   q_addr[$];
    int           q_cyc[$];

    logic [288:0] pipe[RD_LAT];
    logic         prev_stall = 1'b0;
    logic [288:0] prev_data;
    logic [3:0]   prev_idx;
    logic         prev_last;
    logic [8:0]   prev_addr = 9'd0;
    logic         prev_done = 1'b0;

    always #5 clk = ~clk;

    pairing_result_reader #(
        .RD_LAT      (RD_LAT),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .n_words     (n_words),
        .busy_in     (busy_in),
        .extout_addr (extout_addr),
        .extout_data (extout_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .active      (active),
        .done        (done),
        .err         (err)
    );

    task automatic check_val(input string tag, input logic [288:0] got, input logic [288:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory stub: RD_LAT register stages between address and data.
    always @(posedge clk) begin
        pipe[0] <= 289'(extout_addr) * 289'd3 + 289'd1;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign extout_data = pipe[RD_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_idx.push_back(m_index);
            q_last.push_back(m_last);
            q_addr.push_back(extout_addr);
            q_cyc.push_back(cyc);
        end
        if (prev_stall && m_valid) begin
            check_val("stall_data", m_data, prev_data);
            check_val("stall_index", 289'(m_index), 289'(prev_idx));
            check_val("stall_last", 289'(m_last), 289'(prev_last));
        end
        if (prev_done && done) check_val("done_width", 289'(done), 289'd0);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_idx   = m_index;
        prev_last  = m_last;
        prev_done  = done;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (m_valid) valid_cnt++;
        if (extout_addr != prev_addr) addr_chg++;
        prev_addr = extout_addr;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 3) == 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic do_start(input logic [8:0] b, input logic [4:0] n);
        q_data.delete(); q_idx.delete(); q_last.delete(); q_addr.delete(); q_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        @(posedge clk); #1;
        base_addr = b; n_words = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_val({tag, "_done_cnt"}, 289'(done_cnt), 289'd1);
        check_val({tag, "_active_low"}, 289'(active), 289'd0);
    endtask

    task automatic check_beats(input string tag, input logic [8:0] b, input int n, input bit gap_chk);
        logic [8:0] a;
        check_val({tag, "_beats"}, 289'(q_data.size()), 289'(n));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            a = b + 9'(i);
            check_val({tag, "_data"}, q_data[i], 289'(a) * 289'd3 + 289'd1);
            check_val({tag, "_index"}, 289'(q_idx[i]), 289'(i));
            check_val({tag, "_last"}, 289'(q_last[i]), 289'(i == n - 1));
            check_val({tag, "_addr"}, 289'(q_addr[i]), 289'(a));
            if (gap_chk && i > 0) check_val({tag, "_gap"}, 289'(q_cyc[i] - q_cyc[i-1]), 289'd5);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_addr"}, 289'(extout_addr), 289'd0);
        check_val({tag, "_mdata"}, m_data, 289'd0);
        check_val({tag, "_mvalid"}, 289'(m_valid), 289'd0);
        check_val({tag, "_mindex"}, 289'(m_index), 289'd0);
        check_val({tag, "_mlast"}, 289'(m_last), 289'd0);
        check_val({tag, "_active"}, 289'(active), 289'd0);
        check_val({tag, "_done"}, 289'(done), 289'd0);
        check_val({tag, "_err"}, 289'(err), 289'd0);
    endtask

    initial begin
        int a_chg0, v0, bw;
        logic [8:0] a0;
        rstn = 1'b0; start = 1'b0; base_addr = 9'd0; n_words = 5'd0; busy_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Basic 12-word read at full throughput.
        ready_mode = 0;
        do_start(9'h010, 5'd12);
        wait_done("full");
        check_beats("full", 9'h010, 12, 1'b1);

        // Same read with back-pressure.
        ready_mode = 1;
        do_start(9'h010, 5'd12);
        wait_done("stall");
        check_beats("stall", 9'h010, 12, 1'b0);
        ready_mode = 0;

        // Busy held after start; second start must be ignored.
`ifdef PAIRING_RDR_TIMEOUT_EN
        bw = 40;
`else
        bw = 500;
`endif
        busy_in = 1'b1;
        do_start(9'h010, 5'd12);
        a0 = extout_addr; a_chg0 = addr_chg; v0 = valid_cnt;
        repeat (100) @(posedge clk);
        #1; base_addr = 9'h100; n_words = 5'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (bw - 101) @(posedge clk);
        @(negedge clk);
        check_val("busy_addr_hold", 289'(extout_addr), 289'(a0));
        check_val("busy_addr_chg", 289'(addr_chg - a_chg0), 289'd0);
        check_val("busy_no_valid", 289'(valid_cnt - v0), 289'd0);
        check_val("busy_active", 289'(active), 289'd1);
        @(posedge clk); #1; busy_in = 1'b0;
        wait_done("busy");
        check_beats("busy", 9'h010, 12, 1'b1);

        // Address wrap at the top of the 9-bit space.
        do_start(9'h1FC, 5'd8);
        wait_done("wrap");
        check_beats("wrap", 9'h1FC, 8, 1'b1);

        // Zero-length block and oversized count.
        do_start(9'h020, 5'd0);
        wait_done("zero");
        check_val("zero_beats", 289'(q_data.size()), 289'd0);
        do_start(9'h000, 5'd20);
        wait_done("clamp");
        check_beats("clamp", 9'h000, 16, 1'b1);

        // Busy held indefinitely.
        busy_in = 1'b1;
        v0 = valid_cnt;
        do_start(9'h040, 5'd2);
        repeat (100) @(negedge clk);
`ifdef PAIRING_RDR_TIMEOUT_EN
        check_val("to_err_cnt", 289'(err_cnt), 289'd1);
        check_val("to_active", 289'(active), 289'd0);
`else
        check_val("to_err_cnt", 289'(err_cnt), 289'd0);
        check_val("to_active", 289'(active), 289'd1);
`endif
        check_val("to_no_valid", 289'(valid_cnt - v0), 289'd0);
        @(posedge clk); #1; rstn = 1'b0; busy_in = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;

        // Reset while beat index 4 is being presented.
        do_start(9'h010, 5'd12);
        for (int k = 0; k < 500 && q_data.size() < 4; k++) @(negedge clk);
        ready_mode = 2; m_ready = 1'b0;
        for (int k = 0; k < 100 && !(m_valid && m_index == 4'd4); k++) @(negedge clk);
        check_val("rst_mid_beat4", 289'(m_valid && m_index == 4'd4), 289'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        check_val("rst_mid_no_done", 289'(done_cnt), 289'd0);
        rstn = 1'b1; ready_mode = 0;
        do_start(9'h010, 5'd12);
        wait_done("after_rst");
        check_beats("after_rst", 9'h010, 12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
